timer_cmd_sequencer: RTL and testbench

Command queue and dispatcher that sits directly upstream of the countdown timer (Start/Pause/Tiempo in, Busy out).
- Accepts {action, duration} commands from the control logic and buffers them in a small FIFO.
- Launches each command's duration on the timer and holds the command's action code on Action for the whole run.
- Detects completion correctly even though the timer's Busy also drops while paused.
- Provides flush/abort.

---
 rtl/timer_seq_pkg.sv | 18 +
 rtl/cmd_fifo.sv | 59 +++++
 rtl/timer_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_timer_cmd_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_pkg.sv
// Shared types and defaults for the timer command sequencer.
package timer_seq_pkg;

  localparam int unsigned DEF_DEPTH    = 8;
  localparam int unsigned DEF_ACTION_W = 3;
  localparam int unsigned DEF_TIME_W   = 16;

  // Action code meaning "stop/idle"; driven whenever no command is running.
  localparam int unsigned ACTION_IDLE  = 0;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    ARM,
    RUN
  } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO. Pushes against a full FIFO are dropped and
// flagged on Overflow one cycle later, even when a pop happens in the same
// cycle. Clear empties the FIFO and suppresses any push or pop that cycle.
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 19
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Clear,
  input  logic                     Push,
  input  logic [WIDTH-1:0]         PushData,
  input  logic                     Pop,
  output logic [WIDTH-1:0]         PopData,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign Full    = (Count == (AW+1)'(DEPTH));
  assign Empty   = (Count == '0);
  assign wr_en   = Push && !Full && !Clear;
  assign rd_en   = Pop && !Empty && !Clear;
  assign PopData = mem[rd_ptr];

  // Storage, wrapping pointers, occupancy and the dropped-push flag.
  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= PushData;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
      Overflow <= Push && Full;
    end
  end

endmodule

// File: rtl/timer_cmd_sequencer.sv
// Command queue and dispatcher feeding a countdown timer. Each queued
// {action, duration} is launched on the timer and its action code is held
// on Action until the timer finishes; pauses are not mistaken for completion.
module timer_cmd_sequencer
  import timer_seq_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned ACTION_W = DEF_ACTION_W,
  parameter int unsigned TIME_W   = DEF_TIME_W
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Push,
  input  logic [ACTION_W-1:0]      PushAction,
  input  logic [TIME_W-1:0]        PushTime,
  input  logic                     Abort,
  input  logic                     Pause,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic                     TimerStart,
  output logic [TIME_W-1:0]        TimerTiempo,
  output logic                     TimerPause,
  output logic                     TimerReset,
  input  logic                     TimerBusy,
  output logic [ACTION_W-1:0]      Action,
  output logic                     Done
);

  seq_state_t                 state;
  seq_state_t                 state_nx;
  logic [ACTION_W-1:0]        cur_action;
  logic [TIME_W-1:0]          cur_time;
  logic [ACTION_W+TIME_W-1:0] head;
  logic                       pop;
  logic                       pause_d;
  logic                       complete;
  logic                       done_q;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ACTION_W + TIME_W)
  ) u_fifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .Clear    (Abort),
    .Push     (Push),
    .PushData ({PushAction, PushTime}),
    .Pop      (pop),
    .PopData  (head),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow)
  );

  assign TimerPause = Pause;
  assign TimerReset = Reset || Abort;
  assign Done       = done_q;

  // Next-state, pop request and timer-facing outputs.
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    complete    = 1'b0;
    TimerStart  = 1'b0;
    TimerTiempo = '0;
    Action      = ACTION_W'(ACTION_IDLE);
    case (state)
      IDLE: begin
        if (!Empty && !Pause && !Abort) begin
          pop      = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        Action      = cur_action;
        TimerTiempo = cur_time;
        TimerStart  = !Pause;
        if (!Pause) state_nx = ARM;
      end
      ARM: begin
        Action = cur_action;
        if (TimerBusy) state_nx = RUN;
      end
      RUN: begin
        Action = cur_action;
        // Busy also drops while paused and for the cycle after release,
        // so only a quiet Pause over two samples means the run is over.
        complete = !TimerBusy && !Pause && !pause_d;
        if (complete) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, current command latch, pause history and Done pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cur_action <= '0;
      cur_time   <= '0;
      pause_d    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pause_d <= Pause;
      if (Abort) begin
        state  <= IDLE;
        done_q <= 1'b0;
      end else begin
        state  <= state_nx;
        done_q <= complete;
        if (pop) {cur_action, cur_time} <= head;
      end
    end
  end

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Directed bench: a behavioural countdown timer drives TimerBusy, a queue
// based model predicts the sequencer outputs, and every cycle is compared.
module tb_timer_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TW    = 16;

  logic          Clock      = 1'b0;
  logic          Reset      = 1'b1;
  logic          Push       = 1'b0;
  logic [AW-1:0] PushAction = '0;
  logic [TW-1:0] PushTime   = '0;
  logic          Abort      = 1'b0;
  logic          Pause      = 1'b0;
  logic          TimerBusy  = 1'b0;

  logic                    Full, Empty, Overflow, TimerStart, TimerPause, TimerReset, Done;
  logic [$clog2(DEPTH):0]  Count;
  logic [TW-1:0]           TimerTiempo;
  logic [AW-1:0]           Action;

  always #5 Clock = ~Clock;

  timer_cmd_sequencer #(
    .DEPTH    (DEPTH),
    .ACTION_W (AW),
    .TIME_W   (TW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Push        (Push),
    .PushAction  (PushAction),
    .PushTime    (PushTime),
    .Abort       (Abort),
    .Pause       (Pause),
    .Full        (Full),
    .Empty       (Empty),
    .Count       (Count),
    .Overflow    (Overflow),
    .TimerStart  (TimerStart),
    .TimerTiempo (TimerTiempo),
    .TimerPause  (TimerPause),
    .TimerReset  (TimerReset),
    .TimerBusy   (TimerBusy),
    .Action      (Action),
    .Done        (Done)
  );

  // Countdown timer: Start sampled only when unpaused, Busy for Tiempo+1
  // unpaused cycles, Busy low while paused.
  logic          tm_running = 1'b0;
  logic [TW-1:0] tm_left    = '0;
  always @(posedge Clock) begin
    if (TimerReset) begin
      tm_running <= 1'b0;
      tm_left    <= '0;
      TimerBusy  <= 1'b0;
    end else if (TimerPause) begin
      TimerBusy <= 1'b0;
    end else if (tm_running) begin
      if (tm_left == 0) begin
        tm_running <= 1'b0;
        TimerBusy  <= 1'b0;
      end else begin
        tm_left   <= tm_left - 1'b1;
        TimerBusy <= 1'b1;
      end
    end else if (TimerStart) begin
      tm_running <= 1'b1;
      tm_left    <= TimerTiempo;
      TimerBusy  <= 1'b1;
    end
  end

  // Sequencer model: a command is waiting (0), launching (1) or on the
  // timer (2); it finishes once the timer has stopped and Pause was low
  // on this and the previous sample.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [TW-1:0] t;
  } cmd_t;

  cmd_t          mq[$];
  int            m_phase = 0;
  logic [AW-1:0] m_act   = '0;
  logic [TW-1:0] m_time  = '0;
  logic          m_done  = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_pd    = 1'b0;

  always @(posedge Clock) begin
    cmd_t c;
    bit   was_full;
    if (Reset) begin
      mq.delete();
      m_phase = 0; m_act = '0; m_time = '0;
      m_done = 1'b0; m_ovf = 1'b0; m_pd = 1'b0;
    end else if (Abort) begin
      mq.delete();
      m_phase = 0; m_done = 1'b0; m_ovf = 1'b0; m_pd = Pause;
    end else begin
      was_full = (mq.size() == DEPTH);
      m_done   = 1'b0;
      if (m_phase == 0) begin
        if (mq.size() > 0 && !Pause) begin
          c = mq.pop_front();
          m_act = c.a; m_time = c.t; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!Pause) m_phase = 2;
      end else if (!tm_running && !Pause && !m_pd) begin
        m_phase = 0; m_done = 1'b1;
      end
      m_ovf = Push && was_full;
      if (Push && !was_full) begin
        c.a = PushAction; c.t = PushTime;
        mq.push_back(c);
      end
      m_pd = Pause;
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  int n_busy = 0, n_done = 0, n_start = 0, n_ovf = 0;
  int done_at = -1;
  logic [AW-1:0] prev_act = '0;
  logic [AW-1:0] act_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // One clock cycle: compare everything against the model mid-cycle,
  // gather event statistics, then advance past the next rising edge.
  task automatic cyc();
    @(negedge Clock);
    chk("Action",      32'(Action),      (m_phase != 0) ? 32'(m_act) : 32'd0);
    chk("TimerStart",  32'(TimerStart),  32'(m_phase == 1 && !Pause));
    chk("TimerTiempo", 32'(TimerTiempo), (m_phase == 1) ? 32'(m_time) : 32'd0);
    chk("Done",        32'(Done),        32'(m_done));
    chk("Overflow",    32'(Overflow),    32'(m_ovf));
    chk("Count",       32'(Count),       32'(mq.size()));
    chk("Full",        32'(Full),        32'(mq.size() == DEPTH));
    chk("Empty",       32'(Empty),       32'(mq.size() == 0));
    chk("TimerPause",  32'(TimerPause),  32'(Pause));
    chk("TimerReset",  32'(TimerReset),  32'(Reset || Abort));
    if (TimerBusy) n_busy++;
    if (TimerStart && !Pause) n_start++;
    if (Overflow) n_ovf++;
    if (Done) begin n_done++; done_at = cyc_no; end
    if (Action != prev_act && Action != '0) act_log.push_back(Action);
    prev_act = Action;
    @(posedge Clock);
    #1;
    cyc_no++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [TW-1:0] t);
    Push = 1'b1; PushAction = a; PushTime = t;
    cyc();
    Push = 1'b0;
  endtask

  int n0, b0, d0, s0, o0;

  initial begin
    @(posedge Clock);
    #1;
    cyc();
    // Reset state
    chk("rst_count", 32'(Count), 0);
    chk("rst_empty", 32'(Empty), 1);
    chk("rst_full",  32'(Full), 0);
    chk("rst_action", 32'(Action), 0);
    chk("rst_done",  32'(Done), 0);
    chk("rst_start", 32'(TimerStart), 0);
    Reset = 1'b0;
    run(2);

    // 1: single command, act=2 T=3
    b0 = n_busy; d0 = n_done; s0 = n_start;
    push(3'd2, 16'd3);
    n0 = cyc_no;
    cyc();
    chk("t1_action_n1", 32'(Action), 2);
    chk("t1_start_n1", 32'(TimerStart), 1);
    run(11);
    chk("t1_busy_cycles", 32'(n_busy - b0), 4);
    chk("t1_done_pulses", 32'(n_done - d0), 1);
    chk("t1_start_pulses", 32'(n_start - s0), 1);
    chk("t1_done_at", 32'(done_at - n0), 7);
    chk("t1_action_idle", 32'(Action), 0);

    // 2: three back-to-back commands including T=0
    act_log.delete();
    b0 = n_busy; d0 = n_done;
    push(3'd1, 16'd0);
    n0 = cyc_no;
    push(3'd2, 16'd5);
    push(3'd3, 16'd1);
    run(28);
    chk("t2_log_size", 32'(act_log.size()), 3);
    if (act_log.size() == 3) begin
      chk("t2_act0", 32'(act_log[0]), 1);
      chk("t2_act1", 32'(act_log[1]), 2);
      chk("t2_act2", 32'(act_log[2]), 3);
    end
    chk("t2_busy_cycles", 32'(n_busy - b0), 9);
    chk("t2_done_pulses", 32'(n_done - d0), 3);
    chk("t2_last_done_at", 32'(done_at - n0), 18);
    chk("t2_empty", 32'(Empty), 1);

    // 3: pause for 4 cycles mid-run of (4,10)
    act_log.delete();
    b0 = n_busy; d0 = n_done;
    push(3'd4, 16'd10);
    n0 = cyc_no;
    run(4);
    Pause = 1'b1;
    run(4);
    Pause = 1'b0;
    run(20);
    chk("t3_busy_cycles", 32'(n_busy - b0), 11);
    chk("t3_done_pulses", 32'(n_done - d0), 1);
    chk("t3_done_at", 32'(done_at - n0), 18);
    chk("t3_actions", 32'(act_log.size()), 1);

    // 4: overfill while a long command runs, then abort with a push while full
    push(3'd5, 16'd60);
    run(3);
    o0 = n_ovf; d0 = n_done;
    for (int i = 0; i < DEPTH; i++) push(3'(i % 7 + 1), 16'd0);
    chk("t4_count_full", 32'(Count), 8);
    chk("t4_full", 32'(Full), 1);
    push(3'd6, 16'd0);
    cyc();
    chk("t4_count_after_drop", 32'(Count), 8);
    chk("t4_ovf_pulses", 32'(n_ovf - o0), 1);
    Abort = 1'b1; Push = 1'b1; PushAction = 3'd7; PushTime = 16'd4;
    #1;
    chk("t4_timer_reset", 32'(TimerReset), 1);
    cyc();
    Abort = 1'b0; Push = 1'b0;
    chk("t4_abort_count", 32'(Count), 0);
    chk("t4_abort_action", 32'(Action), 0);
    run(3);
    chk("t4_no_new_ovf", 32'(n_ovf - o0), 1);
    chk("t4_no_done", 32'(n_done - d0), 0);

    // 5: abort during RUN with 3 queued plus a simultaneous push
    push(3'd6, 16'd30);
    run(5);
    push(3'd1, 16'd2);
    push(3'd2, 16'd2);
    push(3'd3, 16'd2);
    chk("t5_count_queued", 32'(Count), 3);
    o0 = n_ovf; d0 = n_done;
    Abort = 1'b1; Push = 1'b1; PushAction = 3'd7; PushTime = 16'd1;
    #1;
    chk("t5_timer_reset", 32'(TimerReset), 1);
    cyc();
    Abort = 1'b0; Push = 1'b0;
    chk("t5_count", 32'(Count), 0);
    chk("t5_empty", 32'(Empty), 1);
    chk("t5_action", 32'(Action), 0);
    run(5);
    chk("t5_no_done", 32'(n_done - d0), 0);
    chk("t5_no_ovf", 32'(n_ovf - o0), 0);

    // 6: pause held in IDLE blocks the pop until released
    d0 = n_done;
    Pause = 1'b1;
    push(3'd2, 16'd1);
    push(3'd3, 16'd0);
    run(3);
    chk("t6_count_held", 32'(Count), 2);
    chk("t6_action_idle", 32'(Action), 0);
    chk("t6_no_start", 32'(TimerStart), 0);
    Pause = 1'b0;
    cyc();
    chk("t6_popped_action", 32'(Action), 2);
    chk("t6_count_after_pop", 32'(Count), 1);
    run(20);
    chk("t6_done_pulses", 32'(n_done - d0), 2);

    // 7: reset mid-run
    push(3'd1, 16'd20);
    run(6);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("t7_action", 32'(Action), 0);
    chk("t7_count", 32'(Count), 0);
    chk("t7_tiempo", 32'(TimerTiempo), 0);
    run(4);
    chk("t7_busy_low", 32'(TimerBusy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
